// File: rtl/dft_pkg.sv
// Shared types and constants for the 64-point DFT sample framer.
//
// A frame is N_LANE*N_LANE real samples. Replay presents it as N_LANE groups
// of N_LANE lanes with a stride of N_LANE samples between neighbouring lanes.
package dft_pkg;

   localparam int SAMPLE_W  = 16;
   localparam int N_LANE    = 8;               // only 8 is supported
   localparam int FRAME_LEN = N_LANE * N_LANE; // 64 samples per frame

   typedef logic [SAMPLE_W-1:0] sample_t;
   typedef sample_t [0:N_LANE-1] sample_vec_t;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ISSUE     = 2'd1,
      WAIT_DONE = 2'd2
   } framer_state_e;

endpackage

// File: rtl/dft64_frame_bank.sv
// One 64-sample frame store organised as 8 lanes x 8 words.
//
// Sample index i of a frame lives at lane i[5:3], word i[2:0]. Reading word g
// across all lanes therefore returns x[g + 8*m] on lane m, i.e. one stride-8
// group, without any address arithmetic.
//
// Ports:
//   clk        clock
//   i_we       write enable for one sample
//   i_wr_lane  lane of the sample being written
//   i_wr_addr  word within the lane
//   i_wr_data  sample value
//   i_rd_addr  common word address for the 8-wide combinational read
//   o_rd_data  lane 0..7 of the addressed word
module dft64_frame_bank
   import dft_pkg::*;
(
   input  logic        clk,
   input  logic        i_we,
   input  logic [2:0]  i_wr_lane,
   input  logic [2:0]  i_wr_addr,
   input  sample_t     i_wr_data,
   input  logic [2:0]  i_rd_addr,
   output sample_vec_t o_rd_data
);

   sample_t r_mem [0:N_LANE-1][0:N_LANE-1];

   // Storage is deliberately not reset: the full flags in the parent decide
   // whether the contents are meaningful.
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_wr_lane][i_wr_addr] <= i_wr_data;
      end
   end

   always_comb begin
      o_rd_data = '0;
      for (int m = 0; m < N_LANE; m++) begin
         o_rd_data[m] = r_mem[m][i_rd_addr];
      end
   end

endmodule

// File: rtl/dft64_sample_framer.sv
// Upstream feeder for the 64-point DFT stage.
//
// Serial 16-bit samples are written into ping-pong 64-sample banks. Each full
// bank is replayed as 8 stride-8 groups (group g, lane m = x[g + 8*m]) on 8
// consecutive cycles, then the calculate window stays open until the DFT
// stage pulses dft_done, which frees the bank.
//
// Handshake: a sample transfers on a rising edge where in_valid && in_ready;
// in_ready depends only on registers (and sreset), never on in_valid, and an
// in_valid while in_ready is low is ignored.
//
// Ports:
//   clk          clock, rising edge
//   sreset       synchronous active-high reset
//   in_valid     in_sample valid this cycle
//   in_ready     framer can accept in_sample
//   in_sample    input sample, natural time order
//   out_samples  registered group lanes [0:7]
//   out_rel      group release strobe, 8 consecutive cycles per frame
//   out_calc     calculate window to the DFT stage
//   dft_done     single-cycle completion pulse from the DFT stage
//   busy         a bank holds a frame or a frame is being replayed
//   dbg_state    current read-side FSM state
module dft64_sample_framer
   import dft_pkg::*;
(
   input  logic          clk,
   input  logic          sreset,
   input  logic          in_valid,
   output logic          in_ready,
   input  sample_t       in_sample,
   output sample_vec_t   out_samples,
   output logic          out_rel,
   output logic          out_calc,
   input  logic          dft_done,
   output logic          busy,
   output framer_state_e dbg_state
);

   // Write side
   logic          r_wr_bank;
   logic [5:0]    r_wr_idx;
   logic [1:0]    r_full;
   logic          w_accept;
   logic          w_frame_done;
   logic [1:0]    w_we;
   logic [1:0]    w_full_set;
   logic [1:0]    w_full_clr;

   // Read side
   logic          r_rd_bank;
   framer_state_e r_state;
   framer_state_e w_state_nxt;
   logic [2:0]    r_g;
   logic [2:0]    w_g_nxt;
   logic          w_load;
   logic          w_rel_nxt;
   logic          w_calc_nxt;
   logic          w_release;
   sample_vec_t   w_rd_bank0;
   sample_vec_t   w_rd_bank1;
   sample_vec_t   w_rd_group;

   // Output registers
   sample_vec_t   r_out_samples;
   logic          r_out_rel;
   logic          r_out_calc;

   assign in_ready     = !sreset && !r_full[r_wr_bank];
   assign w_accept     = in_valid && in_ready;
   assign w_frame_done = w_accept && (r_wr_idx == 6'd63);
   assign w_we         = {w_accept && r_wr_bank, w_accept && !r_wr_bank};

   dft64_frame_bank u_bank0 (
      .clk       (clk),
      .i_we      (w_we[0]),
      .i_wr_lane (r_wr_idx[5:3]),
      .i_wr_addr (r_wr_idx[2:0]),
      .i_wr_data (in_sample),
      .i_rd_addr (r_g),
      .o_rd_data (w_rd_bank0)
   );

   dft64_frame_bank u_bank1 (
      .clk       (clk),
      .i_we      (w_we[1]),
      .i_wr_lane (r_wr_idx[5:3]),
      .i_wr_addr (r_wr_idx[2:0]),
      .i_wr_data (in_sample),
      .i_rd_addr (r_g),
      .o_rd_data (w_rd_bank1)
   );

   // r_g is 0 whenever the FSM is in IDLE (reset value, and it wraps 7->0 on
   // the last ISSUE), so it can drive the read address in every state.
   assign w_rd_group = r_rd_bank ? w_rd_bank1 : w_rd_bank0;

   always_comb begin
      w_state_nxt = r_state;
      w_g_nxt     = r_g;
      w_load      = 1'b0;
      w_rel_nxt   = 1'b0;
      w_calc_nxt  = r_out_calc;
      w_release   = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (r_full[r_rd_bank]) begin
               w_load      = 1'b1;
               w_rel_nxt   = 1'b1;
               w_calc_nxt  = 1'b1;
               w_g_nxt     = 3'd1;
               w_state_nxt = ISSUE;
            end
         end
         ISSUE: begin
            w_load    = 1'b1;
            w_rel_nxt = 1'b1;
            w_g_nxt   = r_g + 3'd1;
            if (r_g == 3'd7) begin
               w_state_nxt = WAIT_DONE;
            end
         end
         WAIT_DONE: begin
            if (dft_done) begin
               w_release   = 1'b1;
               w_calc_nxt  = 1'b0;
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_g_nxt     = 3'd0;
            w_calc_nxt  = 1'b0;
            w_state_nxt = IDLE;
         end
      endcase
   end

   // Set and clear never target the same bank (the writer skips full banks),
   // so they can be applied independently in one edge.
   assign w_full_set = w_frame_done ? (r_wr_bank ? 2'b10 : 2'b01) : 2'b00;
   assign w_full_clr = w_release    ? (r_rd_bank ? 2'b10 : 2'b01) : 2'b00;

   always_ff @(posedge clk) begin
      if (sreset) begin
         r_wr_bank     <= 1'b0;
         r_rd_bank     <= 1'b0;
         r_wr_idx      <= 6'd0;
         r_full        <= 2'b00;
         r_state       <= IDLE;
         r_g           <= 3'd0;
         r_out_samples <= '0;
         r_out_rel     <= 1'b0;
         r_out_calc    <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_g        <= w_g_nxt;
         r_out_rel  <= w_rel_nxt;
         r_out_calc <= w_calc_nxt;
         r_full     <= (r_full & ~w_full_clr) | w_full_set;
         if (w_load) begin
            r_out_samples <= w_rd_group;
         end
         if (w_accept) begin
            r_wr_idx <= r_wr_idx + 6'd1; // wraps to 0 after sample 63
         end
         if (w_frame_done) begin
            r_wr_bank <= ~r_wr_bank;
         end
         if (w_release) begin
            r_rd_bank <= ~r_rd_bank;
         end
      end
   end

   assign out_samples = r_out_samples;
   assign out_rel     = r_out_rel;
   assign out_calc    = r_out_calc;
   assign busy        = (|r_full) || (r_state != IDLE);
   assign dbg_state   = r_state;

endmodule

// File: tb/tb_dft64_sample_framer.sv
module tb_dft64_sample_framer;
   import dft_pkg::*;

   // ---------------- clock / reset / DUT ----------------
   logic          clk = 1'b0;
   logic          sreset;
   logic          in_valid;
   logic          in_ready;
   sample_t       in_sample;
   sample_vec_t   out_samples;
   logic          out_rel;
   logic          out_calc;
   logic          dft_done;
   logic          busy;
   framer_state_e dbg_state;

   always #5 clk = ~clk;

   dft64_sample_framer dut (
      .clk         (clk),
      .sreset      (sreset),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_sample   (in_sample),
      .out_samples (out_samples),
      .out_rel     (out_rel),
      .out_calc    (out_calc),
      .dft_done    (dft_done),
      .busy        (busy),
      .dbg_state   (dbg_state)
   );

   // ---------------- reference model ----------------
   // cur_q: samples of the frame being assembled.
   // exp_q: completed frames awaiting release, 64 samples each, oldest first.
   // A frame being replayed stays at the head of exp_q until dft_done.
   logic [SAMPLE_W-1:0] cur_q[$];
   logic [SAMPLE_W-1:0] exp_q[$];
   bit          m_active;   // a frame is replaying or awaiting dft_done
   int          m_sent;     // groups released for the head frame
   bit          m_rel;
   bit          m_calc;
   sample_vec_t m_out;

   int n_checks;
   int n_pass;
   int n_acc;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
   endtask

   function automatic sample_vec_t head_group(input int g);
      sample_vec_t v;
      for (int m = 0; m < N_LANE; m++) v[m] = exp_q[g + N_LANE * m];
      return v;
   endfunction

   function automatic sample_vec_t ramp_group(input int base, input int g);
      sample_vec_t v;
      for (int m = 0; m < N_LANE; m++) v[m] = sample_t'(base + g + N_LANE * m);
      return v;
   endfunction

   // Effect of one rising edge, given the inputs presented for it.
   task automatic model_edge();
      int frames_before;
      frames_before = exp_q.size() / FRAME_LEN;
      if (sreset) begin
         cur_q.delete();
         exp_q.delete();
         m_active = 1'b0;
         m_sent   = 0;
         m_rel    = 1'b0;
         m_calc   = 1'b0;
         m_out    = '0;
         return;
      end
      // read side: sees only frames complete before this edge
      if (!m_active) begin
         m_rel = 1'b0;
         if (frames_before > 0) begin
            m_out    = head_group(0);
            m_rel    = 1'b1;
            m_calc   = 1'b1;
            m_sent   = 1;
            m_active = 1'b1;
         end
      end else if (m_sent < N_LANE) begin
         m_out  = head_group(m_sent);
         m_rel  = 1'b1;
         m_sent = m_sent + 1;
      end else begin
         m_rel = 1'b0;
         if (dft_done) begin
            for (int i = 0; i < FRAME_LEN; i++) void'(exp_q.pop_front());
            m_calc   = 1'b0;
            m_active = 1'b0;
            m_sent   = 0;
         end
      end
      // write side: room exists while fewer than two frames are held
      if (in_valid && frames_before < 2) begin
         cur_q.push_back(in_sample);
         if (cur_q.size() == FRAME_LEN) begin
            foreach (cur_q[i]) exp_q.push_back(cur_q[i]);
            cur_q.delete();
         end
      end
   endtask

   task automatic check_outputs();
      check("in_ready", in_ready, !sreset && (exp_q.size() / FRAME_LEN) < 2);
      check("out_rel", out_rel, m_rel);
      check("out_calc", out_calc, m_calc);
      check("busy", busy, exp_q.size() > 0 || m_active);
      check("out_samples", out_samples, m_out);
      check("state_idle", dbg_state == IDLE, !m_active);
   endtask

   // ---------------- driver ----------------
   task automatic step(input bit v, input sample_t s, input bit d, input bit r);
      in_valid  = v;
      in_sample = s;
      dft_done  = d;
      sreset    = r;
      #1;
      if (v && in_ready && !r) n_acc++;
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_outputs();
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(1'b0, '0, 1'b0, 1'b0);
   endtask

   task automatic ramp(input int base, input int n);
      for (int i = 0; i < n; i++) step(1'b1, sample_t'(base + i), 1'b0, 1'b0);
   endtask

   // idle until the head frame has released all 8 groups
   task automatic wait_done_state();
      int k;
      k = 0;
      while (!(m_active && m_sent == N_LANE) && k < 40) begin
         idle(1);
         k++;
      end
      check("wait_done_reached", m_active && m_sent == N_LANE, 1'b1);
   endtask

   // ---------------- stimulus ----------------
   int rel_cnt;
   int k;

   initial begin
      n_checks  = 0;
      n_pass    = 0;
      n_acc     = 0;
      in_valid  = 1'b0;
      in_sample = '0;
      dft_done  = 1'b0;
      sreset    = 1'b1;
      m_active  = 1'b0;
      m_sent    = 0;
      m_rel     = 1'b0;
      m_calc    = 1'b0;
      m_out     = '0;

      @(negedge clk);
      step(1'b0, '0, 1'b0, 1'b1);
      step(1'b0, '0, 1'b0, 1'b1);
      check("reset_out_samples", out_samples, '0);

      // 1: single ramp frame, check release burst length and stride groups
      ramp(0, 64);
      rel_cnt = 0;
      for (int c = 0; c < 12; c++) begin
         idle(1);
         if (out_rel) begin
            rel_cnt++;
            if (rel_cnt == 4) check("t1_group3", out_samples, ramp_group(0, 3));
            if (rel_cnt == 8) check("t1_group7", out_samples, ramp_group(0, 7));
         end
      end
      check("t1_rel_len", rel_cnt, 8);
      check("t1_calc_held", out_calc, 1'b1);
      step(1'b0, '0, 1'b1, 1'b0);
      check("t1_calc_dropped", out_calc, 1'b0);
      idle(2);

      // 2: overfill with dft_done withheld; two extra samples are refused
      n_acc = 0;
      ramp(64, 130);
      check("t2_accepts", n_acc, 128);
      wait_done_state();
      step(1'b0, '0, 1'b1, 1'b0);
      check("t2_ready_back", in_ready, 1'b1);
      wait_done_state();
      step(1'b0, '0, 1'b1, 1'b0);
      idle(2);

      // 3: back-to-back frames, dft_done 5 cycles after the first burst
      ramp(1000, 128);
      wait_done_state();
      idle(5);
      step(1'b0, '0, 1'b1, 1'b0);
      step(1'b0, '0, 1'b0, 1'b0);
      check("t3_next_rel", out_rel, 1'b1);
      wait_done_state();
      step(1'b0, '0, 1'b1, 1'b0);
      idle(2);

      // 4: reset while group 4 is on the outputs
      ramp(0, 64);
      k = 0;
      while (!(m_rel && m_sent == 5) && k < 20) begin
         idle(1);
         k++;
      end
      check("t4_group4_seen", out_samples, ramp_group(0, 4));
      step(1'b0, '0, 1'b0, 1'b1);
      check("t4_rel_cleared", out_rel, 1'b0);
      idle(12);
      ramp(100, 64);
      k = 0;
      while (!out_rel && k < 10) begin
         idle(1);
         k++;
      end
      check("t4_fresh_group0", out_samples, ramp_group(100, 0));
      wait_done_state();
      step(1'b0, '0, 1'b1, 1'b0);
      idle(2);

      // 5: gappy input with dft_done pulses while the read side is idle
      for (int i = 0; i < 128; i++) begin
         step(i % 2 == 0, sample_t'(200 + i / 2), (i % 7 == 3) && !m_active, 1'b0);
      end
      wait_done_state();
      step(1'b0, '0, 1'b1, 1'b0);
      idle(2);

      // 6: bank 1 completes on the same edge dft_done frees bank 0
      ramp(300, 64);
      wait_done_state();
      ramp(400, 63);
      step(1'b1, sample_t'(463), 1'b1, 1'b0);
      check("t6_busy", busy, 1'b1);
      step(1'b0, '0, 1'b0, 1'b0);
      check("t6_replay_start", out_samples, ramp_group(400, 0));
      wait_done_state();
      step(1'b0, '0, 1'b1, 1'b0);
      idle(2);

      // randomized traffic
      for (int c = 0; c < 1500; c++) begin
         step($urandom_range(0, 3) != 0, sample_t'($urandom),
              $urandom_range(0, 9) == 0, $urandom_range(0, 399) == 0);
      end
      idle(20);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
